// File: rtl/duck_shot_pkg.sv
// Shared types and helpers for the duck-layer light-gun detector.
// The state enum, luma width and luma helper live here so other frame-paced blocks can reuse them.
package duck_shot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FLASH,
    REPORT,
    COOLDOWN
  } state_e;

  localparam int LUMA_W = 6;

  // Brightness proxy: plain sum of the three 4-bit channels, 0..45.
  function automatic logic [LUMA_W-1:0] rgb_luma(input logic [11:0] rgb);
    return LUMA_W'(rgb[11:8]) + LUMA_W'(rgb[7:4]) + LUMA_W'(rgb[3:0]);
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// One-cycle frame marker on the rising edge of vblank.
// The edge detector holds the previous vblank level in a register.
module vga_frame_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vblnk_i,
  output logic frame_o
);

  logic vblnk_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vblnk_q <= 1'b0;
    else        vblnk_q <= vblnk_i;
  end

  assign frame_o = vblnk_i & ~vblnk_q;

endmodule

// File: rtl/duck_shot_detect.sv
// Light-gun back end: on a trigger edge, requests a flash frame and samples the stream at the cursor.
// At the end of the frame it reports hit/miss, then holds off new shots for a cooldown.
module duck_shot_detect
  import duck_shot_pkg::*;
#(
  parameter int LUMA_THRESHOLD  = 36,
  parameter int FLASH_FRAMES    = 1,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vga_hcount_i,
  input  logic [10:0] vga_vcount_i,
  input  logic        vga_hblnk_i,
  input  logic        vga_vblnk_i,
  input  logic [11:0] vga_rgb_i,
  input  logic        trigger_i,
  input  logic [9:0]  cursor_x_i,
  input  logic [9:0]  cursor_y_i,
  output logic        flash_o,
  output logic        busy_o,
  output logic        shot_hit_o,
  output logic        shot_miss_o,
  output logic [11:0] sample_rgb_o
);

  localparam logic [7:0]        FC_LAST  = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0]        CD_LAST  = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [LUMA_W-1:0] LUMA_THR = LUMA_W'(LUMA_THRESHOLD);

  state_e              state_q, state_d;
  logic                flash_q, flash_d;
  logic [9:0]          cx_q, cx_d, cy_q, cy_d;
  logic                sampled_q, sampled_d;
  logic [11:0]         rgb_q, rgb_d;
  logic [LUMA_W-1:0]   luma_q, luma_d;
  logic [7:0]          fc_q, fc_d, cd_q, cd_d;
  logic                trigger_q;
  logic                fr, trig_rise, pix_match, is_hit;

  vga_frame_edge u_frame_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .vblnk_i (vga_vblnk_i),
    .frame_o (fr)
  );

  assign trig_rise = trigger_i & ~trigger_q;
  assign pix_match = (vga_hcount_i == {1'b0, cx_q}) && (vga_vcount_i == {1'b0, cy_q})
                     && !vga_hblnk_i && !vga_vblnk_i;

  // NOTE: every register in this block is small control or data state, so all of it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flash_q   <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      sampled_q <= 1'b0;
      rgb_q     <= '0;
      luma_q    <= '0;
      fc_q      <= '0;
      cd_q      <= '0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flash_q   <= flash_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      sampled_q <= sampled_d;
      rgb_q     <= rgb_d;
      luma_q    <= luma_d;
      fc_q      <= fc_d;
      cd_q      <= cd_d;
      trigger_q <= trigger_i;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    flash_d   = flash_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sampled_d = sampled_q;
    rgb_d     = rgb_q;
    luma_d    = luma_q;
    fc_d      = fc_q;
    cd_d      = cd_q;
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          cx_d      = cursor_x_i;
          cy_d      = cursor_y_i;
          sampled_d = 1'b0;
          state_d   = ARM;
        end
      end
      ARM: begin
        // Raising flash at vblank gives upstream stages a whole blanking period to react.
        if (fr) begin
          flash_d = 1'b1;
          fc_d    = '0;
          state_d = FLASH;
        end
      end
      FLASH: begin
        if (pix_match && !sampled_q) begin
          rgb_d     = vga_rgb_i;
          luma_d    = rgb_luma(vga_rgb_i);
          sampled_d = 1'b1;
        end
        if (fr) begin
          if (fc_q == FC_LAST) begin
            flash_d = 1'b0;
            state_d = REPORT;
          end else begin
            fc_d = fc_q + 8'd1;
          end
        end
      end
      REPORT: begin
        cd_d    = '0;
        state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (fr) begin
          if (cd_q == CD_LAST) state_d = IDLE;
          else                 cd_d    = cd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_hit       = sampled_q && (luma_q >= LUMA_THR);
  assign flash_o      = flash_q;
  assign busy_o       = (state_q != IDLE);
  assign shot_hit_o   = (state_q == REPORT) && is_hit;
  assign shot_miss_o  = (state_q == REPORT) && !is_hit;
  assign sample_rgb_o = rgb_q;

endmodule

// File: tb/tb_duck_shot_detect.sv
// Bench for duck_shot_detect on a coarse 800x560 raster (40-pixel stride, 280 clocks per frame).
// A shot-level model is compared every cycle; directed shots pin literal outcomes.
module tb_duck_shot_detect;

  localparam int FRAME = 280;
  localparam int COOL  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vga_hcount = '0;
  logic [10:0] vga_vcount = '0;
  logic        vga_hblnk = 1'b0;
  logic        vga_vblnk = 1'b0;
  logic [11:0] vga_rgb = '0;
  logic        trigger;
  logic [9:0]  cursor_x, cursor_y;
  logic        flash_o, busy_o, shot_hit_o, shot_miss_o;
  logic [11:0] sample_rgb_o;

  int checks = 0;
  int errors = 0;

  int          tgt_x = 0, tgt_y = 0;
  logic [11:0] tgt_rgb = '0;

  int cyc = 0, n_hit = 0, n_miss = 0, flash_cycles = 0, pulse_cyc = 0, cool_span = 0;
  bit busy_prev = 1'b0;

  always #5 clk = ~clk;

  duck_shot_detect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_hcount_i (vga_hcount),
    .vga_vcount_i (vga_vcount),
    .vga_hblnk_i  (vga_hblnk),
    .vga_vblnk_i  (vga_vblnk),
    .vga_rgb_i    (vga_rgb),
    .trigger_i    (trigger),
    .cursor_x_i   (cursor_x),
    .cursor_y_i   (cursor_y),
    .flash_o      (flash_o),
    .busy_o       (busy_o),
    .shot_hit_o   (shot_hit_o),
    .shot_miss_o  (shot_miss_o),
    .sample_rgb_o (sample_rgb_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Raster source: the target pixel is lit only while flash is requested.
  int gh = 0, gv = 0;
  initial forever begin
    @(posedge clk);
    #1;
    gh += 40;
    if (gh == 800) begin
      gh = 0;
      gv += 40;
      if (gv == 560) gv = 0;
    end
    vga_hcount = 11'(gh);
    vga_vcount = 11'(gv);
    vga_hblnk  = (gh >= 640);
    vga_vblnk  = (gv >= 480);
    vga_rgb    = (flash_o && gh == tgt_x && gv == tgt_y) ? tgt_rgb : 12'h000;
  end

  // Shot-level model: phase 0 idle, 1 waiting for frame, 2 flashing, 3 reporting, 4 cooling down.
  int          m_phase = 0, m_frames_left = 0, m_cool_left = 0, m_x = 0, m_y = 0;
  bit          m_got = 1'b0, m_vb_prev = 1'b0, m_trig_prev = 1'b0;
  bit [11:0]   m_rgb = '0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_got = 1'b0; m_rgb = '0; m_vb_prev = 1'b0; m_trig_prev = 1'b0;
    end else begin
      bit frame_start, press;
      frame_start = vga_vblnk && !m_vb_prev;
      press       = trigger && !m_trig_prev;
      m_vb_prev   = vga_vblnk;
      m_trig_prev = trigger;
      case (m_phase)
        0: if (press) begin
             m_x = int'(cursor_x); m_y = int'(cursor_y); m_got = 1'b0; m_phase = 1;
           end
        1: if (frame_start) begin m_phase = 2; m_frames_left = 1; end
        2: begin
             if (!m_got && int'(vga_hcount) == m_x && int'(vga_vcount) == m_y
                 && !vga_hblnk && !vga_vblnk) begin
               m_got = 1'b1; m_rgb = vga_rgb;
             end
             if (frame_start) begin
               m_frames_left--;
               if (m_frames_left == 0) m_phase = 3;
             end
           end
        3: begin m_phase = (COOL == 0) ? 0 : 4; m_cool_left = COOL; end
        default: if (frame_start) begin
             m_cool_left--;
             if (m_cool_left == 0) m_phase = 0;
           end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    begin
      bit exp_hit;
      exp_hit = m_got && (int'(m_rgb[11:8]) + int'(m_rgb[7:4]) + int'(m_rgb[3:0]) >= 36);
      check("model_flash", flash_o, m_phase == 2);
      check("model_busy", busy_o, m_phase != 0);
      check("model_hit", shot_hit_o, m_phase == 3 && exp_hit);
      check("model_miss", shot_miss_o, m_phase == 3 && !exp_hit);
      check("model_rgb", sample_rgb_o, m_rgb);
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (flash_o) flash_cycles++;
    if (shot_hit_o)  begin n_hit++;  pulse_cyc = cyc; end
    if (shot_miss_o) begin n_miss++; pulse_cyc = cyc; end
    if (busy_prev && !busy_o) cool_span = cyc - pulse_cyc;
    busy_prev = busy_o;
  end

  task automatic pulse_trigger(input int n);
    @(posedge clk); #1 trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 25 * FRAME && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1'b1;
    end
    check({name, "_idle_timeout"}, done, 1'b1);
  endtask

  task automatic wait_flash(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      @(negedge clk);
      if (flash_o) done = 1'b1;
    end
    check({name, "_flash_timeout"}, done, 1'b1);
  endtask

  task automatic aim(input int x, input int y, input logic [11:0] pix);
    cursor_x = 10'(x); cursor_y = 10'(y);
    tgt_x = x; tgt_y = y; tgt_rgb = pix;
  endtask

  task automatic do_shot(input int x, input int y, input logic [11:0] pix,
                         input bit exp_hit, input logic [11:0] exp_rgb, input string name);
    int h0, m0, f0;
    aim(x, y, pix);
    h0 = n_hit; m0 = n_miss; f0 = flash_cycles;
    pulse_trigger(3);
    cursor_x = 10'd5; cursor_y = 10'd7;
    wait_idle(name);
    @(posedge clk); #1;
    check({name, "_hits"}, n_hit - h0, exp_hit ? 1 : 0);
    check({name, "_misses"}, n_miss - m0, exp_hit ? 0 : 1);
    check({name, "_flash_len"}, flash_cycles - f0, FRAME);
    check({name, "_sample_rgb"}, sample_rgb_o, exp_rgb);
    check({name, "_cooldown_len"}, cool_span, COOL * FRAME);
  endtask

  initial begin
    int p0, h0;
    rst_n = 1'b0; trigger = 1'b0; cursor_x = '0; cursor_y = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_flash", flash_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_hit", shot_hit_o, 1'b0);
    check("reset_miss", shot_miss_o, 1'b0);
    check("reset_rgb", sample_rgb_o, 12'h000);
    rst_n = 1'b1;
    repeat (FRAME + 37) @(posedge clk);

    do_shot(320, 240, 12'hFFF, 1'b1, 12'hFFF, "hit");
    do_shot(320, 240, 12'h111, 1'b0, 12'h111, "dark");
    do_shot(320, 240, 12'hCCC, 1'b1, 12'hCCC, "luma36");
    do_shot(320, 240, 12'hCCB, 1'b0, 12'hCCB, "luma35");
    do_shot(700, 500, 12'hFFF, 1'b0, 12'hCCB, "offscreen");
    do_shot(680, 240, 12'hFFF, 1'b0, 12'hCCB, "hblank");
    do_shot(320, 480, 12'hFFF, 1'b0, 12'hCCB, "vblank");

    // Extra edges in ARM/FLASH, FLASH, and COOLDOWN must all be ignored.
    aim(320, 240, 12'hFFF);
    p0 = n_hit + n_miss; h0 = n_hit;
    pulse_trigger(2);
    repeat (3) @(posedge clk);
    pulse_trigger(2);
    wait_flash("spam");
    repeat (20) @(posedge clk);
    pulse_trigger(2);
    repeat (FRAME + 100) @(posedge clk);
    pulse_trigger(2);
    wait_idle("spam");
    @(posedge clk); #1;
    check("spam_reports", n_hit + n_miss - p0, 1);
    check("spam_hits", n_hit - h0, 1);

    // A level held through the return to IDLE must not start a second shot.
    p0 = n_hit + n_miss;
    @(posedge clk); #1 trigger = 1'b1;
    repeat (3) @(posedge clk);
    wait_idle("held");
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("held_no_retrigger", busy_o, 1'b0);
    check("held_reports", n_hit + n_miss - p0, 1);
    trigger = 1'b0;
    repeat (5) @(posedge clk);
    do_shot(320, 240, 12'hFFF, 1'b1, 12'hFFF, "fresh");

    // Async reset in the middle of the flash frame.
    aim(320, 240, 12'hFFF);
    pulse_trigger(2);
    wait_flash("rst");
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_flash", flash_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_hit", shot_hit_o, 1'b0);
    check("rst_miss", shot_miss_o, 1'b0);
    check("rst_rgb", sample_rgb_o, 12'h000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    p0 = n_hit + n_miss;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    check("rst_no_report", n_hit + n_miss - p0, 0);
    check("rst_stays_idle", busy_o, 1'b0);
    do_shot(320, 240, 12'hFFF, 1'b1, 12'hFFF, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
